// File: rtl/nixie_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g,dp}, active-high.
package nixie_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Packed table: element [n] is the pattern for hex digit n (MSB listed first).
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex -> 7-segment decoder; the dp bit is always 0 here and is
// merged by the caller.
module seg7_hex_decode
    import nixie_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/nixie_scan_ctrl.sv
// Multiplexed scan controller: shadow/active digit buffers, one shared
// decoder, blanking guard at the start of every digit slot.
//
//  state | meaning
//  OFF   | display dark, counters parked at 0, pending commits copy at once
//  BLANK | start of a slot, all digits deselected to avoid ghosting
//  SHOW  | digit idx selected, segments driven from the active buffer
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int NUM_DIG   = 8,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500,
    localparam int AW       = $clog2(NUM_DIG),
    localparam int CW       = $clog2(SLOT_CYC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [3:0]         wr_data,
    input  logic               wr_dp,
    input  logic               commit,
    output logic               commit_ack,
    output logic               frame_start,
    output logic [7:0]         seg,
    output logic [NUM_DIG-1:0] dig_sel_n
);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIG - 1);

    scan_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] idx, idx_n;
    logic          pending, pending_n;

    // Each buffer entry is {dp, hex}.
    logic [NUM_DIG-1:0][4:0] shadow;
    logic [NUM_DIG-1:0][4:0] active;

    logic               boundary;
    logic               copy;
    logic               wr_ok;
    logic               frame_start_n;
    logic [7:0]         seg_n;
    logic [NUM_DIG-1:0] dig_sel_n_n;
    logic [3:0]         dec_in;
    logic               dec_dp;
    logic [7:0]         dec_seg;

    seg7_hex_decode u_dec (
        .hex (dec_in),
        .seg (dec_seg)
    );

    assign wr_ok = 32'(wr_addr) < 32'(NUM_DIG);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        idx_n         = idx;
        frame_start_n = 1'b0;
        boundary      = 1'b0;

        case (state)
            OFF: begin
                cnt_n = '0;
                idx_n = '0;
                if (en) begin
                    state_n       = BLANK;
                    frame_start_n = 1'b1;
                end
            end
            BLANK: begin
                cnt_n = cnt + CW'(1);
                if (cnt == BLANK_LAST) begin
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (cnt == SLOT_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    if (idx == IDX_LAST) begin
                        idx_n         = '0;
                        boundary      = 1'b1;
                        frame_start_n = 1'b1;
                    end else begin
                        idx_n = idx + AW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = OFF;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        // Disable wins over everything: a partial frame is simply abandoned.
        if (!en) begin
            state_n       = OFF;
            cnt_n         = '0;
            idx_n         = '0;
            frame_start_n = 1'b0;
            boundary      = 1'b0;
        end

        copy      = pending && (boundary || state == OFF);
        pending_n = copy ? 1'b0 : (pending | commit);
    end

    // Outputs are computed for the state being entered so they register on
    // the same edge; active only changes on edges that enter BLANK or OFF.
    always_comb begin
        dec_in      = active[idx_n][3:0];
        dec_dp      = active[idx_n][4];
        seg_n       = SEG_BLANK;
        dig_sel_n_n = '1;
        if (state_n == SHOW) begin
            seg_n              = dec_seg | {7'b0, dec_dp};
            dig_sel_n_n[idx_n] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            cnt         <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            shadow      <= '0;
            active      <= '0;
            commit_ack  <= 1'b0;
            frame_start <= 1'b0;
            seg         <= SEG_BLANK;
            dig_sel_n   <= '1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            pending     <= pending_n;
            commit_ack  <= copy;
            frame_start <= frame_start_n;
            seg         <= seg_n;
            dig_sel_n   <= dig_sel_n_n;
            if (copy) begin
                active <= shadow;
            end
            if (wr_en && wr_ok) begin
                shadow[wr_addr] <= {wr_dp, wr_data};
            end
        end
    end

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Bench for nixie_scan_ctrl: frame-position reference model plus directed
// scenarios and a randomized write/commit/enable phase.
module tb_nixie_scan_ctrl;

    localparam int NUM_DIG   = 4;
    localparam int SLOT_CYC  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = NUM_DIG * SLOT_CYC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, wr_en, wr_dp, commit;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit_ack, frame_start;
    logic [7:0] seg;
    logic [3:0] dig_sel_n;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int a0;

    logic [7:0] tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    // Model: running flag plus position within the frame.
    bit       m_run;
    int       m_p;
    bit       m_pend, m_ack;
    logic [4:0] m_shadow [NUM_DIG];
    logic [4:0] m_active [NUM_DIG];

    nixie_scan_ctrl #(
        .NUM_DIG   (NUM_DIG),
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .commit      (commit),
        .commit_ack  (commit_ack),
        .frame_start (frame_start),
        .seg         (seg),
        .dig_sel_n   (dig_sel_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin : mdl
        bit cp;
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_p    <= 0;
            m_pend <= 1'b0;
            m_ack  <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                m_shadow[i] <= '0;
                m_active[i] <= '0;
            end
        end else begin
            cp = m_pend && (!m_run || (en && m_p == FRAME - 1));
            if (cp) m_active <= m_shadow;
            if (wr_en) m_shadow[wr_addr] <= {wr_dp, wr_data};
            m_pend <= cp ? 1'b0 : (m_pend | commit);
            m_ack  <= cp;
            if (!en) begin
                m_run <= 1'b0;
                m_p   <= 0;
            end else if (!m_run) begin
                m_run <= 1'b1;
                m_p   <= 0;
            end else begin
                m_p <= (m_p + 1) % FRAME;
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int slot, off;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        slot  = m_p / SLOT_CYC;
        off   = m_p % SLOT_CYC;
        e_sel = 4'hF;
        e_seg = 8'h00;
        if (m_run && off >= BLANK_CYC) begin
            e_sel[slot] = 1'b0;
            e_seg = tbl[m_active[slot][3:0]] | {7'b0, m_active[slot][4]};
        end
        lit("model_sel", 32'(dig_sel_n), 32'(e_sel));
        lit("model_seg", 32'(seg), 32'(e_seg));
        lit("model_frame_start", 32'(frame_start), 32'(m_run && m_p == 0));
        lit("model_ack", 32'(commit_ack), 32'(m_ack));
        if (commit_ack === 1'b1) ack_cnt++;
    endtask

    // Advance n cycles; returns 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; wr_dp = 1'b0; commit = 1'b0;
        #2 rst_n = 1'b0;
        cyc(3);
        lit("rst_seg", 32'(seg), 32'h00);
        lit("rst_sel", 32'(dig_sel_n), 32'hF);
        lit("rst_ack", 32'(commit_ack), 32'h0);
        lit("rst_fs", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // Scan start and first frame
        en = 1'b1;
        cyc(1); #3;
        lit("start_fs", 32'(frame_start), 32'h1);
        lit("start_sel", 32'(dig_sel_n), 32'hF);
        cyc(2); #3;
        lit("d0_sel", 32'(dig_sel_n), 32'hE);
        lit("d0_seg", 32'(seg), 32'hFC);
        cyc(30); #3;
        lit("frame2_fs", 32'(frame_start), 32'h1);

        // Mid-frame commit only lands at the boundary
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h7; wr_dp = 1'b1;
        cyc(1);
        wr_en = 1'b0; commit = 1'b1;
        cyc(1);
        commit = 1'b0;
        cyc(16); #3;
        lit("d2_old_sel", 32'(dig_sel_n), 32'hB);
        lit("d2_old_seg", 32'(seg), 32'hFC);
        cyc(14); #3;
        lit("boundary_ack", 32'(commit_ack), 32'h1);
        cyc(1); #3;
        lit("ack_drop", 32'(commit_ack), 32'h0);
        cyc(17); #3;
        lit("d2_new_sel", 32'(dig_sel_n), 32'hB);
        lit("d2_new_seg", 32'(seg), 32'hE1);

        // Writes without commit leave the display alone
        for (int i = 0; i < NUM_DIG; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'(i + 8); wr_dp = i[0];
            cyc(1);
        end
        wr_en = 1'b0;
        cyc(96); #3;
        lit("nocommit_seg", 32'(seg), 32'hE1);

        // Disable, commit while dark, re-enable
        en = 1'b0;
        cyc(1); #3;
        lit("off_sel", 32'(dig_sel_n), 32'hF);
        lit("off_seg", 32'(seg), 32'h00);
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
        cyc(1); #3;
        lit("off_ack", 32'(commit_ack), 32'h1);
        en = 1'b1;
        cyc(1); #3;
        lit("reen_fs", 32'(frame_start), 32'h1);
        lit("reen_sel", 32'(dig_sel_n), 32'hF);
        cyc(2); #3;
        lit("reen_d0_seg", 32'(seg), 32'hFE);

        // Merged commits give a single ack
        commit = 1'b1; cyc(1); commit = 1'b0;
        cyc(2);
        commit = 1'b1; cyc(1); commit = 1'b0;
        a0 = ack_cnt;
        cyc(40); #3;
        lit("merged_acks", 32'(ack_cnt - a0), 32'h1);

        // Commit and write on the copy edge
        commit = 1'b1; cyc(1); commit = 1'b0;
        cyc(16);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h3; wr_dp = 1'b0; commit = 1'b1;
        a0 = ack_cnt;
        cyc(1);
        wr_en = 1'b0; commit = 1'b0; #3;
        lit("copyedge_ack", 32'(commit_ack), 32'h1);
        cyc(2); #3;
        lit("copyedge_prewrite", 32'(seg), 32'hFE);
        cyc(38); #3;
        lit("copyedge_acks", 32'(ack_cnt - a0), 32'h1);
        commit = 1'b1; cyc(1); commit = 1'b0;
        cyc(25); #3;
        lit("kept_write_seg", 32'(seg), 32'hF2);
        lit("kept_write_sel", 32'(dig_sel_n), 32'hE);

        // Asynchronous reset during SHOW
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        lit("async_seg", 32'(seg), 32'h00);
        lit("async_sel", 32'(dig_sel_n), 32'hF);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        cyc(2); #3;
        lit("post_rst_d0", 32'(seg), 32'hFC);
        lit("post_rst_sel0", 32'(dig_sel_n), 32'hE);
        cyc(24); #3;
        lit("post_rst_d3", 32'(seg), 32'hFC);
        lit("post_rst_sel3", 32'(dig_sel_n), 32'h7);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            en      = ($urandom_range(0, 63) != 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(0, 15));
            wr_dp   = $urandom_range(0, 1);
            commit  = ($urandom_range(0, 19) == 0);
            cyc(1);
        end
        en = 1'b1; wr_en = 1'b0; commit = 1'b0;
        cyc(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
